debounce_sync: RTL and testbench

- Input-conditioning stage placed directly upstream of the flip-flop stages.
- Takes a raw asynchronous switch/button line, synchronises it to clk and debounces it with a stability counter.
- Produces a clean level plus one-cycle edge strobes.
- The active-low strobe outputs are intended to drive the active-low set/reset/din inputs of the downstream flip-flops without extra glue.

---
 rtl/debounce_sync_if.sv | 43 ++++
 rtl/debounce_sync.sv | 149 ++++++++++++++
 tb/tb_debounce_sync.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw button / enable in, debounced level, strobes, busy out.
// master drives btn_in/enable; slave (the debouncer) drives the rest.
interface debounce_sync_if;
  logic       btn_in;
  logic       enable;
  logic       level_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       rise_n;
  logic       fall_n;
  logic       busy;
`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] glitch_cnt;
`endif

  modport master (
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    input  glitch_cnt,
`endif
    output btn_in,
    output enable,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  rise_n,
    input  fall_n,
    input  busy
  );

  modport slave (
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    output glitch_cnt,
`endif
    input  btn_in,
    input  enable,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output rise_n,
    output fall_n,
    output busy
  );
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchroniser + stability-counter debouncer with strobes.
// Ports: clk, reset (async, active-low), bus (debounce_sync_if.slave).
// Optional DEBOUNCE_GLITCH_COUNT_EN adds bus.glitch_cnt (aborted episodes).
module debounce_sync #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           reset,
  debounce_sync_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             rise_n_q;
  logic             fall_n_q;

  logic             differ;
  logic             stay;
  logic             grow;
  logic             fire;

  assign differ = sync2_q ^ level_q;
  assign stay   = ~differ;
  assign grow   = differ & (cnt_q != LAST);
  assign fire   = differ & (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      rise_n_q <= 1'b1;
      fall_n_q <= 1'b1;
    end else begin
      sync1_q  <= bus.btn_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      rise_n_q <= ~rise_d;
      fall_n_q <= ~fall_d;
    end
  end

  // With enable low everything holds, so a
  // count in progress resumes where it left off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (bus.enable) begin
      unique case (1'b1)
        stay: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        grow: begin
          state_d = COUNT;
          cnt_d   = cnt_q + 1'b1;
        end
        fire: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.rise_n     = rise_n_q;
  assign bus.fall_n     = fall_n_q;
  assign bus.busy       = (state_q == COUNT);

`ifdef DEBOUNCE_GLITCH_COUNT_EN
  logic [7:0] glitch_q;
  logic [7:0] glitch_d;
  logic       abort;

  // A bounce back to the current level while
  // counting ends the episode without a toggle.
  assign abort = bus.enable & stay
               & (state_q == COUNT);

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != 8'hFF))
      glitch_d = glitch_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) glitch_q <= 8'd0;
    else        glitch_q <= glitch_d;
  end

  assign bus.glitch_cnt = glitch_q;
`endif

`ifndef SYNTHESIS
  a_cnt_bound: assert property (
    @(posedge clk) disable iff (!reset)
    int'(cnt_q) < STABLE_CYCLES);

  a_strobe_excl: assert property (
    @(posedge clk) disable iff (!reset)
    !(rise_q && fall_q));

  a_strobe_n: assert property (
    @(posedge clk) disable iff (!reset)
    (rise_n_q == !rise_q) && (fall_n_q == !fall_q));

  a_idle_zero: assert property (
    @(posedge clk) disable iff (!reset)
    (state_q == IDLE) |-> (cnt_q == '0));
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: table vectors (STABLE_CYCLES=1), directed sequences and
// random stimulus (STABLE_CYCLES=16) against a run-length reference model.
module tb_debounce_sync;

  localparam int S = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  debounce_sync_if if16 ();
  debounce_sync_if if1 ();

  debounce_sync #(
    .STABLE_CYCLES(S),
    .CNT_W(8)
  ) dut16 (
    .clk(clk),
    .reset(reset),
    .bus(if16.slave)
  );

  debounce_sync #(
    .STABLE_CYCLES(1),
    .CNT_W(8)
  ) dut1 (
    .clk(clk),
    .reset(reset),
    .bus(if1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: level flips once S consecutive
  // enabled samples of the synchronised input
  // (input delayed by two edges) disagree with it.
  logic m_lvl;
  logic m_rise;
  logic m_fall;
  logic m_busy;
  int   m_glitch;
  logic hist[$];
  int   run_len;

  typedef struct {
    logic btn;
    logic lvl;
    logic rise;
    logic fall;
  } vec_t;

  vec_t tbl[18];
  logic [0:17] v_btn  = 18'b111101111100010000;
  logic [0:17] v_lvl  = 18'b001111011111000100;
  logic [0:17] v_rise = 18'b001000010000000100;
  logic [0:17] v_fall = 18'b000000100000100010;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    run_len  = 0;
    m_lvl    = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_busy   = 1'b0;
    m_glitch = 0;
  endtask

  task automatic model_step(input logic b,
                            input logic en);
    logic s;
    s = hist[hist.size()-2];
    hist.push_back(b);
    if (hist.size() > 4) void'(hist.pop_front());
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (en) begin
      if (s == m_lvl) begin
        if (run_len > 0 && m_glitch < 255)
          m_glitch++;
        run_len = 0;
      end else begin
        run_len++;
        if (run_len == S) begin
          m_lvl   = s;
          m_rise  = s;
          m_fall  = !s;
          run_len = 0;
        end
      end
    end
    m_busy = (run_len > 0);
  endtask

  task automatic chk_model();
    chk("m_level", 8'(if16.level_out), 8'(m_lvl));
    chk("m_rise", 8'(if16.rise_pulse), 8'(m_rise));
    chk("m_fall", 8'(if16.fall_pulse), 8'(m_fall));
    chk("m_rise_n", 8'(if16.rise_n), 8'(!m_rise));
    chk("m_fall_n", 8'(if16.fall_n), 8'(!m_fall));
    chk("m_busy", 8'(if16.busy), 8'(m_busy));
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    chk("m_glitch", if16.glitch_cnt, 8'(m_glitch));
`endif
  endtask

  task automatic step(input logic b, input logic en);
    if16.btn_in = b;
    if16.enable = en;
    @(posedge clk);
    #1;
    model_step(b, en);
    chk_model();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic rb;
    int   seg;

    for (int i = 0; i < 18; i++) begin
      tbl[i].btn  = v_btn[i];
      tbl[i].lvl  = v_lvl[i];
      tbl[i].rise = v_rise[i];
      tbl[i].fall = v_fall[i];
    end

    reset       = 1'b0;
    if16.btn_in = 1'b0;
    if16.enable = 1'b1;
    if1.btn_in  = 1'b0;
    if1.enable  = 1'b1;
    model_reset();

    // STABLE_CYCLES=1 vectors
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if1.btn_in = tbl[i].btn;
      @(posedge clk);
      #1;
      chk("s1_level", 8'(if1.level_out), 8'(tbl[i].lvl));
      chk("s1_rise", 8'(if1.rise_pulse), 8'(tbl[i].rise));
      chk("s1_fall", 8'(if1.fall_pulse), 8'(tbl[i].fall));
      chk("s1_rise_n", 8'(if1.rise_n), 8'(!tbl[i].rise));
      chk("s1_fall_n", 8'(if1.fall_n), 8'(!tbl[i].fall));
      chk("s1_busy", 8'(if1.busy), 8'd0);
    end

    // reset held with btn high, then release
    if16.btn_in = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_level", 8'(if16.level_out), 8'd0);
    chk("rst_rise_n", 8'(if16.rise_n), 8'd1);
    chk("rst_fall_n", 8'(if16.fall_n), 8'd1);
    chk("rst_busy", 8'(if16.busy), 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_level", 8'(if16.level_out), 8'd0);
    chk("rst_hold_rise", 8'(if16.rise_pulse), 8'd0);
    reset = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step(1'b1, 1'b1);
      chk("rel_level", 8'(if16.level_out), 8'(k >= 18));
      chk("rel_rise", 8'(if16.rise_pulse), 8'(k == 18));
      chk("rel_rise_n", 8'(if16.rise_n), 8'(k != 18));
    end

    // clean release / press / release
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1);
      chk("rel1_fall", 8'(if16.fall_pulse), 8'(k == 18));
      chk("rel1_level", 8'(if16.level_out), 8'(k < 18));
    end
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, 1'b1);
      chk("prs_rise", 8'(if16.rise_pulse), 8'(k == 18));
      chk("prs_level", 8'(if16.level_out), 8'(k >= 18));
    end
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1);
      chk("rel2_fall", 8'(if16.fall_pulse), 8'(k == 18));
      chk("rel2_rise", 8'(if16.rise_pulse), 8'd0);
    end

    // bounce 3 high, 5 low, 2 high, 7 low, then stable high
    repeat (3) begin
      step(1'b1, 1'b1);
      chk("bnc_quiet", 8'(if16.rise_pulse | if16.fall_pulse), 8'd0);
    end
    repeat (5) begin
      step(1'b0, 1'b1);
      chk("bnc_quiet", 8'(if16.rise_pulse | if16.fall_pulse), 8'd0);
    end
    repeat (2) begin
      step(1'b1, 1'b1);
      chk("bnc_quiet", 8'(if16.rise_pulse | if16.fall_pulse), 8'd0);
    end
    repeat (7) begin
      step(1'b0, 1'b1);
      chk("bnc_quiet", 8'(if16.rise_pulse | if16.fall_pulse), 8'd0);
    end
    for (int k = 1; k <= 30; k++) begin
      step(1'b1, 1'b1);
      chk("bnc_rise", 8'(if16.rise_pulse), 8'(k == 18));
    end
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    chk("bnc_glitch", if16.glitch_cnt, 8'd2);
`endif

    // enable freeze at cnt=5
    repeat (20) step(1'b0, 1'b1);
    repeat (7) step(1'b1, 1'b1);
    chk("frz_busy0", 8'(if16.busy), 8'd1);
    repeat (10) begin
      step(1'b1, 1'b0);
      chk("frz_busy", 8'(if16.busy), 8'd1);
      chk("frz_level", 8'(if16.level_out), 8'd0);
      chk("frz_rise", 8'(if16.rise_pulse), 8'd0);
    end
    for (int j = 1; j <= 12; j++) begin
      step(1'b1, 1'b1);
      chk("res_level", 8'(if16.level_out), 8'(j >= 11));
      chk("res_rise", 8'(if16.rise_pulse), 8'(j == 11));
      chk("res_busy", 8'(if16.busy), 8'(j < 11));
    end

    // reset while cnt=10
    repeat (12) step(1'b0, 1'b1);
    chk("mid_busy", 8'(if16.busy), 8'd1);
    chk("mid_level", 8'(if16.level_out), 8'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_level", 8'(if16.level_out), 8'd0);
    chk("mid_rst_busy", 8'(if16.busy), 8'd0);
    chk("mid_rst_fall", 8'(if16.fall_pulse), 8'd0);
    chk("mid_rst_fall_n", 8'(if16.fall_n), 8'd1);
    chk("mid_rst_rise_n", 8'(if16.rise_n), 8'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_hold_level", 8'(if16.level_out), 8'd0);
    chk("mid_hold_fall", 8'(if16.fall_pulse), 8'd0);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1);
      chk("mid_rise", 8'(if16.rise_pulse), 8'(k == 18));
    end

    // random segments, occasional disable and reset
    rb  = 1'b1;
    seg = 0;
    for (int n = 0; n < 4000; n++) begin
      if (seg == 0) begin
        rb  = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 24);
      end
      seg--;
      step(rb, 1'($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 799) == 0) begin
        reset = 1'b0;
        #2;
        model_reset();
        chk("rnd_rst_level", 8'(if16.level_out), 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
